// File: rtl/finalsoc_nios2_gen2_0_cpu_debug_slave_sysclk_q_if.sv
// Bundle between the tck-side debug logic and the system-clock command queue.
// The master side drives update strobes and sampled registers; the slave side drains commands.
interface finalsoc_nios2_gen2_0_cpu_debug_slave_sysclk_q_if #(
  parameter int IR_W   = 2,
  parameter int DATA_W = 38,
  parameter int DEPTH  = 4
);
  localparam int NACT  = 1 << IR_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IR_W-1:0]   ir_in;
  logic [DATA_W-1:0] sr;
  logic              vs_udr;
  logic              vs_uir;
  logic              cmd_ready;
  logic              ovf_clr;
  logic [DATA_W-1:0] jdo;
  logic [IR_W-1:0]   cmd_ir;
  logic [NACT-1:0]   take_action;
  logic [NACT-1:0]   take_no_action;
  logic              uir_pulse;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;

  modport master (
    output ir_in, sr, vs_udr, vs_uir, cmd_ready, ovf_clr,
    input  jdo, cmd_ir, take_action, take_no_action, uir_pulse, fifo_count, overflow
  );

  modport slave (
    input  ir_in, sr, vs_udr, vs_uir, cmd_ready, ovf_clr,
    output jdo, cmd_ir, take_action, take_no_action, uir_pulse, fifo_count, overflow
  );
endinterface

// File: rtl/finalsoc_nios2_gen2_0_cpu_debug_slave_sysclk_q.sv
// System-clock half of the Nios II JTAG debug slave: synchronises update strobes,
// queues {ir, sr} per update-DR and drains them as jdo plus one-hot action strobes.
module finalsoc_nios2_gen2_0_cpu_debug_slave_sysclk_q #(
  parameter int IR_W         = 2,
  parameter int DATA_W       = 38,
  parameter int DEPTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int ACT_BIT      = 34,
  parameter int FLUSH_ON_UIR = 1
) (
  input logic clk,
  input logic reset_n,
  finalsoc_nios2_gen2_0_cpu_debug_slave_sysclk_q_if.slave bus
);
  localparam int NACT  = 1 << IR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = IR_W + DATA_W;

  logic rst_meta, rst_n_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b0;
      rst_n_i  <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n_i  <= rst_meta;
    end
  end

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync, primed;
  logic                   udr_hist, uir_hist;
  logic                   udr_rise, uir_rise;

  // History is pinned high until the chains hold real samples, so a strobe
  // already high when reset releases never looks like a rising edge.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      udr_sync <= '0;
      uir_sync <= '0;
      primed   <= '0;
      udr_hist <= 1'b1;
      uir_hist <= 1'b1;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
      primed   <= {primed[SYNC_STAGES-2:0], 1'b1};
      udr_hist <= primed[SYNC_STAGES-1] ? udr_sync[SYNC_STAGES-1] : 1'b1;
      uir_hist <= primed[SYNC_STAGES-1] ? uir_sync[SYNC_STAGES-1] : 1'b1;
    end
  end

  assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_hist;
  assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_hist;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             flush, full, pop, push, drop, act_sel;
  logic [ENT_W-1:0] rd_ent;
  logic [NACT-1:0]  act_hot;

  always_comb begin
    flush   = uir_rise && (FLUSH_ON_UIR != 0);
    full    = (count == CNT_W'(DEPTH));
    pop     = (count != '0) && bus.cmd_ready && !flush;
    drop    = udr_rise && !flush && full && !pop;
    push    = udr_rise && !drop;
    rd_ent  = mem[rd_ptr];
    act_sel = rd_ent[ACT_BIT];
    act_hot = NACT'(1) << rd_ent[ENT_W-1 -: IR_W];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.ir_in, bus.sr};
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      bus.jdo            <= '0;
      bus.cmd_ir         <= '0;
      bus.take_action    <= '0;
      bus.take_no_action <= '0;
      bus.uir_pulse      <= 1'b0;
      bus.overflow       <= 1'b0;
    end else begin
      bus.take_action    <= '0;
      bus.take_no_action <= '0;
      bus.uir_pulse      <= uir_rise;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      // A flush realigns the read pointer onto the write pointer, keeping any same-cycle push.
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= push ? CNT_W'(1) : '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
      if (pop) begin
        bus.jdo    <= rd_ent[DATA_W-1:0];
        bus.cmd_ir <= rd_ent[ENT_W-1 -: IR_W];
        if (act_sel) bus.take_action    <= act_hot;
        else         bus.take_no_action <= act_hot;
      end
      if (drop)             bus.overflow <= 1'b1;
      else if (bus.ovf_clr) bus.overflow <= 1'b0;
    end
  end

  assign bus.fifo_count = count;
endmodule

// File: tb/tb_finalsoc_nios2_gen2_0_cpu_debug_slave_sysclk_q.sv
// Directed bench for the debug-slave command queue: latency, backpressure,
// overflow, UIR flush, reset behaviour and the no-action strobe.
module tb_finalsoc_nios2_gen2_0_cpu_debug_slave_sysclk_q;
  logic clk;
  logic reset_n;
  int unsigned n_checks;
  int unsigned n_fail;

  finalsoc_nios2_gen2_0_cpu_debug_slave_sysclk_q_if #(.IR_W(2), .DATA_W(38), .DEPTH(4)) bus ();

  finalsoc_nios2_gen2_0_cpu_debug_slave_sysclk_q #(
    .IR_W(2), .DATA_W(38), .DEPTH(4), .SYNC_STAGES(2), .ACT_BIT(34), .FLUSH_ON_UIR(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_udr(input logic [1:0] ir, input logic [37:0] data);
    bus.ir_in  = ir;
    bus.sr     = data;
    bus.vs_udr = 1'b1;
    step(6);
    bus.vs_udr = 1'b0;
    step(4);
  endtask

  logic [1:0]  t2_ir [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
  logic [37:0] t2_sr [4] = '{38'h04_0000_0011, 38'h00_0000_0022, 38'h04_0000_0033, 38'h00_0000_0044};
  logic [3:0]  t2_ta [4] = '{4'b1000, 4'b0000, 4'b0001, 4'b0000};
  logic [3:0]  t2_tn [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b0100};
  logic [3:0]  t3_tn [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b1000};
  logic [37:0] t3_jdo [4] = '{38'h101, 38'h102, 38'h103, 38'hABC};
  logic [3:0]  strobes;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.ir_in = '0; bus.sr = '0; bus.vs_udr = 1'b0; bus.vs_uir = 1'b0;
    bus.cmd_ready = 1'b0; bus.ovf_clr = 1'b0;
    step(2);
    check("rst_jdo", bus.jdo, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_strobes", {bus.take_action, bus.take_no_action, bus.uir_pulse}, 0);
    reset_n = 1'b1;
    step(6);

    // Single command: push after edge k+2, strobe after edge k+3
    bus.cmd_ready = 1'b1; bus.ir_in = 2'd2; bus.sr = 38'h4_1234_5678; bus.vs_udr = 1'b1;
    step();
    check("t1_k0_ta", bus.take_action, 0);
    step();
    check("t1_k1_ta", bus.take_action, 0);
    step();
    check("t1_k2_ta", bus.take_action, 0);
    check("t1_k2_count", bus.fifo_count, 1);
    step();
    check("t1_k3_ta", bus.take_action, 4'b0100);
    check("t1_k3_tn", bus.take_no_action, 0);
    check("t1_jdo", bus.jdo, 38'h4_1234_5678);
    check("t1_cmd_ir", bus.cmd_ir, 2);
    step();
    check("t1_k4_ta", bus.take_action, 0);
    check("t1_jdo_hold", bus.jdo, 38'h4_1234_5678);
    step(2);
    bus.vs_udr = 1'b0;
    step(4);

    // Backpressure
    bus.cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_udr(t2_ir[i], t2_sr[i]);
    check("t2_count4", bus.fifo_count, 4);
    check("t2_ovf", bus.overflow, 0);
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t2_ta%0d", i), bus.take_action, t2_ta[i]);
      check($sformatf("t2_tn%0d", i), bus.take_no_action, t2_tn[i]);
      check($sformatf("t2_jdo%0d", i), bus.jdo, t2_sr[i]);
    end
    step();
    check("t2_idle", {bus.take_action, bus.take_no_action}, 0);
    check("t2_count0", bus.fifo_count, 0);
    check("t2_ovf_end", bus.overflow, 0);
    bus.cmd_ready = 1'b0;

    // Overflow, then push+pop while full
    for (int i = 0; i < 5; i++) do_udr(2'(i), 38'h100 + 38'(i));
    check("t3_count", bus.fifo_count, 4);
    check("t3_ovf_set", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("t3_ovf_clr", bus.overflow, 0);
    bus.ir_in = 2'd3; bus.sr = 38'hABC; bus.vs_udr = 1'b1;
    step(2);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    check("t3_full_count", bus.fifo_count, 4);
    check("t3_full_ovf", bus.overflow, 0);
    check("t3_full_jdo", bus.jdo, 38'h100);
    check("t3_full_tn", bus.take_no_action, 4'b0001);
    step(3);
    bus.vs_udr = 1'b0;
    step(4);
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t3_drain_jdo%0d", i), bus.jdo, t3_jdo[i]);
      check($sformatf("t3_drain_tn%0d", i), bus.take_no_action, t3_tn[i]);
    end
    check("t3_last_ir", bus.cmd_ir, 3);
    step();
    check("t3_count0", bus.fifo_count, 0);
    bus.cmd_ready = 1'b0;

    // UIR flush
    for (int i = 0; i < 3; i++) do_udr(2'd1, 38'h200 + 38'(i));
    check("t4_count3", bus.fifo_count, 3);
    bus.vs_uir = 1'b1;
    step(2);
    check("t4_uir_early", bus.uir_pulse, 0);
    step();
    check("t4_uir_pulse", bus.uir_pulse, 1);
    check("t4_flushed", bus.fifo_count, 0);
    check("t4_no_strobe", {bus.take_action, bus.take_no_action}, 0);
    step();
    check("t4_uir_single", bus.uir_pulse, 0);
    bus.cmd_ready = 1'b1;
    step();
    check("t4_empty_strobe", {bus.take_action, bus.take_no_action}, 0);
    bus.cmd_ready = 1'b0;
    bus.vs_uir = 1'b0;
    step(4);
    for (int i = 0; i < 2; i++) do_udr(2'd2, 38'h300 + 38'(i));
    bus.ir_in = 2'd1; bus.sr = 38'h4_0000_0777; bus.vs_udr = 1'b1; bus.vs_uir = 1'b1;
    step(3);
    check("t4_flush_push_count", bus.fifo_count, 1);
    check("t4_flush_push_uir", bus.uir_pulse, 1);
    step(3);
    bus.vs_udr = 1'b0; bus.vs_uir = 1'b0;
    step(4);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    check("t4_kept_jdo", bus.jdo, 38'h4_0000_0777);
    check("t4_kept_ta", bus.take_action, 4'b0010);

    // Reset mid-operation, then strobe held high across release
    for (int i = 0; i < 2; i++) do_udr(2'd3, 38'h400 + 38'(i));
    reset_n = 1'b0;
    #1;
    check("t5_rst_count", bus.fifo_count, 0);
    check("t5_rst_jdo", bus.jdo, 0);
    check("t5_rst_ir", bus.cmd_ir, 0);
    bus.vs_udr = 1'b1;
    bus.cmd_ready = 1'b1;
    step(2);
    reset_n = 1'b1;
    strobes = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      strobes = strobes | bus.take_action | bus.take_no_action;
    end
    check("t5_held_strobes", strobes, 0);
    check("t5_held_count", bus.fifo_count, 0);
    bus.vs_udr = 1'b0;
    step(4);

    // No-action strobe
    bus.ir_in = 2'd0; bus.sr = 38'h0_0BAD_F00D; bus.vs_udr = 1'b1;
    step(4);
    check("t6_tn", bus.take_no_action, 4'b0001);
    check("t6_ta", bus.take_action, 0);
    check("t6_jdo", bus.jdo, 38'h0_0BAD_F00D);
    step(2);
    bus.vs_udr = 1'b0;
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
